// File: rtl/subneg_pkg.sv
// Shared types for the SUBNEG core control path.
// Sequencer state encoding used by pc_sequencer.
package subneg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/pc_adder.sv
// Unsigned WIDTH-bit adder with carry out; purely combinational, no backpressure.
module pc_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/pc_sequencer.sv
// PC holder and operand-fetch sequencer: one operand address per accepted handshake,
// new PC visible one cycle after exec_done; mem_ready low holds addr/op_idx.
module pc_sequencer
  import subneg_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int OPERANDS    = 3,
  parameter int RESET_PC    = 0,
  parameter int HALT_DETECT = 1
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            start,
  input  logic                            run,
  input  logic                            mem_ready,
  input  logic                            exec_done,
  input  logic                            branch_taken,
  input  logic [WIDTH-1:0]                target,
  output logic [WIDTH-1:0]                addr,
  output logic                            addr_valid,
  output logic [$clog2(OPERANDS+1)-1:0]   op_idx,
  output logic [WIDTH-1:0]                pc,
  output logic                            busy,
  output logic                            halted,
  output logic                            wrap
);

  localparam int              IW       = $clog2(OPERANDS + 1);
  localparam logic [IW-1:0]   LAST_IDX = IW'(OPERANDS - 1);
  localparam logic [WIDTH-1:0] STEP    = WIDTH'(OPERANDS);
  localparam logic [WIDTH-1:0] PC_INIT = WIDTH'(RESET_PC);

  seq_state_t       state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             wrap_q, wrap_d;

  logic [WIDTH-1:0] fetch_addr;
  logic             fetch_carry_unused;
  logic [WIDTH-1:0] pc_step;
  logic             step_carry;

  // Operand addresses wrap silently; only the PC advance reports a carry.
  pc_adder #(.WIDTH(WIDTH)) u_fetch_add (
    .a     (pc_q),
    .b     (WIDTH'(idx_q)),
    .sum   (fetch_addr),
    .carry (fetch_carry_unused)
  );

  pc_adder #(.WIDTH(WIDTH)) u_step_add (
    .a     (pc_q),
    .b     (STEP),
    .sum   (pc_step),
    .carry (step_carry)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= PC_INIT;
      idx_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      idx_q   <= idx_d;
      wrap_q  <= wrap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    idx_d   = idx_q;
    wrap_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          idx_d   = '0;
        end
      end
      FETCH: begin
        if (mem_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = EXEC;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      EXEC: begin
        if (exec_done) begin
          // A taken branch onto itself can never make progress.
          if (branch_taken && (target == pc_q) && (HALT_DETECT != 0)) begin
            state_d = HALT;
          end else begin
            if (branch_taken) begin
              pc_d = target;
            end else begin
              pc_d   = pc_step;
              wrap_d = step_carry;
            end
            state_d = run ? FETCH : IDLE;
          end
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign addr       = fetch_addr;
  assign addr_valid = (state_q == FETCH);
  assign op_idx     = idx_q;
  assign pc         = pc_q;
  assign busy       = (state_q == FETCH) || (state_q == EXEC);
  assign halted     = (state_q == HALT);
  assign wrap       = wrap_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer (WIDTH=8, OPERANDS=3): directed scenarios plus a randomized
// instruction stream scored against a transaction-level PC model.
module tb_pc_sequencer;

  localparam int W   = 8;
  localparam int OPS = 3;
  localparam int IW  = $clog2(OPS + 1);

  logic          clock = 1'b0;
  logic          reset, start, run, mem_ready, exec_done, branch_taken;
  logic [W-1:0]  target;
  logic [W-1:0]  addr, pc;
  logic          addr_valid, busy, halted, wrap;
  logic [IW-1:0] op_idx;

  int checks   = 0;
  int failures = 0;

  pc_sequencer #(.WIDTH(W), .OPERANDS(OPS), .RESET_PC(0), .HALT_DETECT(1)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .run          (run),
    .mem_ready    (mem_ready),
    .exec_done    (exec_done),
    .branch_taken (branch_taken),
    .target       (target),
    .addr         (addr),
    .addr_valid   (addr_valid),
    .op_idx       (op_idx),
    .pc           (pc),
    .busy         (busy),
    .halted       (halted),
    .wrap         (wrap)
  );

  always #5 clock = ~clock;

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic quiet();
    start = 0; run = 0; mem_ready = 0; exec_done = 0; branch_taken = 0; target = '0;
  endtask

  task automatic do_reset();
    reset = 1; tick(); reset = 0;
  endtask

  task automatic fetch_all();
    mem_ready = 1;
    repeat (OPS) tick();
    mem_ready = 0;
  endtask

  task automatic finish_instr(input logic taken, input logic [W-1:0] tgt, input logic r);
    exec_done = 1; branch_taken = taken; target = tgt; run = r;
    tick();
    exec_done = 0; branch_taken = 0;
  endtask

  task automatic test_reset();
    quiet();
    start = 1; mem_ready = 1; exec_done = 1;
    do_reset();
    quiet();
    checks++;
    if ({pc, addr, addr_valid, busy, halted, wrap, op_idx} !== {8'd0, 8'd0, 4'b0000, 2'd0}) begin
      failures++;
      $display("FAIL reset_values pc=%0d addr=%0d v=%b busy=%b halt=%b wrap=%b idx=%0d want all zero",
               pc, addr, addr_valid, busy, halted, wrap, op_idx);
    end
  endtask

  task automatic test_first_fetch();
    start = 1; tick(); start = 0;
    mem_ready = 1;
    for (int k = 0; k < OPS; k++) begin
      checks++;
      if (addr_valid !== 1'b1 || addr !== W'(k) || op_idx !== IW'(k)) begin
        failures++;
        $display("FAIL first_fetch k=%0d got v=%b addr=%0d idx=%0d want v=1 addr=%0d idx=%0d",
                 k, addr_valid, addr, op_idx, k, k);
      end
      tick();
    end
    mem_ready = 0;
    checks++;
    if (addr_valid !== 1'b0 || busy !== 1'b1 || pc !== 8'd0) begin
      failures++;
      $display("FAIL first_exec got v=%b busy=%b pc=%0d want v=0 busy=1 pc=0", addr_valid, busy, pc);
    end
  endtask

  task automatic test_sequential();
    finish_instr(1'b0, 8'd0, 1'b1);
    checks++;
    if (pc !== 8'd3 || wrap !== 1'b0 || addr !== 8'd3 || addr_valid !== 1'b1) begin
      failures++;
      $display("FAIL seq_advance got pc=%0d wrap=%b addr=%0d v=%b want pc=3 wrap=0 addr=3 v=1",
               pc, wrap, addr, addr_valid);
    end
    mem_ready = 1;
    for (int k = 0; k < OPS; k++) begin
      checks++;
      if (addr !== W'(3 + k)) begin
        failures++;
        $display("FAIL seq_fetch k=%0d got addr=%0d want %0d", k, addr, 3 + k);
      end
      tick();
    end
    mem_ready = 0;
  endtask

  task automatic test_wrap();
    finish_instr(1'b1, 8'd254, 1'b1);
    mem_ready = 1;
    for (int k = 0; k < OPS; k++) begin
      checks++;
      if (addr !== W'((254 + k) % 256) || addr_valid !== 1'b1) begin
        failures++;
        $display("FAIL wrap_fetch k=%0d got addr=%0d v=%b want addr=%0d v=1",
                 k, addr, addr_valid, (254 + k) % 256);
      end
      tick();
    end
    mem_ready = 0;
    finish_instr(1'b0, 8'd0, 1'b1);
    checks++;
    if (pc !== 8'd1 || wrap !== 1'b1) begin
      failures++;
      $display("FAIL wrap_pulse got pc=%0d wrap=%b want pc=1 wrap=1", pc, wrap);
    end
    tick();
    checks++;
    if (wrap !== 1'b0) begin
      failures++;
      $display("FAIL wrap_one_cycle got wrap=%b want 0", wrap);
    end
  endtask

  task automatic test_branch_halt();
    fetch_all();
    finish_instr(1'b1, 8'h40, 1'b1);
    checks++;
    if (pc !== 8'h40 || addr !== 8'h40 || addr_valid !== 1'b1 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL branch_taken got pc=%h addr=%h v=%b wrap=%b want pc=40 addr=40 v=1 wrap=0",
               pc, addr, addr_valid, wrap);
    end
    fetch_all();
    finish_instr(1'b1, 8'h40, 1'b1);
    checks++;
    if (halted !== 1'b1 || addr_valid !== 1'b0 || busy !== 1'b0 || pc !== 8'h40) begin
      failures++;
      $display("FAIL halt_enter got halted=%b v=%b busy=%b pc=%h want halted=1 v=0 busy=0 pc=40",
               halted, addr_valid, busy, pc);
    end
    start = 1; mem_ready = 1; exec_done = 1; branch_taken = 1; target = 8'h10; run = 1;
    repeat (4) tick();
    quiet();
    checks++;
    if (halted !== 1'b1 || addr_valid !== 1'b0 || pc !== 8'h40) begin
      failures++;
      $display("FAIL halt_absorbing got halted=%b v=%b pc=%h want halted=1 v=0 pc=40",
               halted, addr_valid, pc);
    end
    do_reset();
    checks++;
    if (halted !== 1'b0 || busy !== 1'b0 || pc !== 8'd0 || addr_valid !== 1'b0) begin
      failures++;
      $display("FAIL halt_reset got halted=%b busy=%b pc=%0d v=%b want 0 0 0 0",
               halted, busy, pc, addr_valid);
    end
  endtask

  task automatic test_stall_and_reset();
    start = 1; tick(); start = 0;
    mem_ready = 1; tick(); mem_ready = 0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (addr !== 8'd1 || op_idx !== 2'd1 || addr_valid !== 1'b1) begin
        failures++;
        $display("FAIL stall_hold c=%0d got addr=%0d idx=%0d v=%b want addr=1 idx=1 v=1",
                 c, addr, op_idx, addr_valid);
      end
      tick();
    end
    mem_ready = 1;
    do_reset();
    mem_ready = 0;
    checks++;
    if (addr_valid !== 1'b0 || busy !== 1'b0 || pc !== 8'd0 || op_idx !== 2'd0) begin
      failures++;
      $display("FAIL fetch_reset got v=%b busy=%b pc=%0d idx=%0d want 0 0 0 0",
               addr_valid, busy, pc, op_idx);
    end
  endtask

  task automatic test_run_low();
    start = 1; tick(); start = 0;
    fetch_all(); finish_instr(1'b0, 8'd0, 1'b1);
    fetch_all(); finish_instr(1'b0, 8'd0, 1'b1);
    fetch_all(); finish_instr(1'b0, 8'd0, 1'b0);
    checks++;
    if (pc !== 8'd9 || addr_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL run_low got pc=%0d v=%b busy=%b want pc=9 v=0 busy=0", pc, addr_valid, busy);
    end
    mem_ready = 1; exec_done = 1;
    repeat (3) tick();
    mem_ready = 0; exec_done = 0;
    checks++;
    if (pc !== 8'd9 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_hold got pc=%0d busy=%b want pc=9 busy=0", pc, busy);
    end
    start = 1; tick(); start = 0;
    checks++;
    if (addr !== 8'd9 || addr_valid !== 1'b1) begin
      failures++;
      $display("FAIL resume got addr=%0d v=%b want addr=9 v=1", addr, addr_valid);
    end
  endtask

  // Each instruction: expect addresses pc, pc+1, pc+2 (mod 256) on accepted handshakes,
  // then the PC rule applied at exec_done.
  task automatic test_random();
    int unsigned m_pc;
    bit          running;
    int          k, budget, sum;
    logic [W-1:0] tgt;
    logic        taken, r;
    quiet();
    do_reset();
    m_pc = 0;
    running = 0;
    for (int n = 0; n < 80; n++) begin
      if (!running) begin
        start = 1; tick(); start = 0;
      end
      k = 0;
      budget = 200;
      while (k < OPS && budget > 0) begin
        mem_ready = 1'($urandom_range(0, 1));
        exec_done = 1'($urandom_range(0, 1));
        start     = 1'($urandom_range(0, 1));
        if (addr_valid === 1'b1 && mem_ready) begin
          checks++;
          if (addr !== W'((m_pc + k) % 256)) begin
            failures++;
            $display("FAIL rand_addr n=%0d k=%0d got %0d want %0d", n, k, addr, (m_pc + k) % 256);
          end
          k++;
        end
        tick();
        budget--;
      end
      quiet();
      if (k < OPS) begin
        failures++;
        $display("FAIL rand_fetch_timeout n=%0d accepted=%0d want %0d", n, k, OPS);
      end
      repeat ($urandom_range(0, 3)) begin
        start = 1'($urandom_range(0, 1));
        tick();
      end
      start = 0;
      checks++;
      if (addr_valid !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL rand_exec_wait n=%0d got v=%b busy=%b want v=0 busy=1", n, addr_valid, busy);
      end
      taken = 1'($urandom_range(0, 1));
      tgt   = W'($urandom_range(0, 255));
      if (tgt == W'(m_pc)) tgt = tgt + 1'b1;
      r     = ($urandom_range(0, 3) != 0);
      finish_instr(taken, tgt, r);
      if (taken) begin
        m_pc = tgt;
        sum  = 0;
      end else begin
        sum  = m_pc + OPS;
        m_pc = sum % 256;
      end
      running = r;
      checks++;
      if (pc !== W'(m_pc) || wrap !== (sum > 255) || busy !== r) begin
        failures++;
        $display("FAIL rand_update n=%0d got pc=%0d wrap=%b busy=%b want pc=%0d wrap=%b busy=%b",
                 n, pc, wrap, busy, m_pc, (sum > 255), r);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    reset = 0;
    quiet();
    test_reset();
    test_first_fetch();
    test_sequential();
    test_wrap();
    test_branch_halt();
    test_stall_and_reset();
    test_run_low();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
